// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types for the I2C bus arbiter: FSM state encoding and the bit
// positions inside the engine address word.
package i2c_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int START_BIT = 8;
  localparam int RW_BIT    = 0;
  localparam int DEV_W     = 7;

endpackage

// File: rtl/i2c_bus_arbiter_rr_select.sv
// Combinational round-robin pick: search starts one past last_winner and wraps.
module rr_select
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [LW-1:0]      last_winner,
  output logic [NUM_REQ-1:0] winner,
  output logic               any
);

  always_comb begin
    int          idx;
    logic [LW-1:0] ix;
    logic        found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    ix     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_winner) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      ix = LW'(idx);
      if (!found && req[ix]) begin
        winner[ix] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C register-access engine among NUM_REQ
// requesters. Define I2C_TIMEOUT_EN to add a watchdog on ISSUE/RUN.
module i2c_bus_arbiter
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [7*NUM_REQ-1:0]   req_dev,
  input  logic [8*NUM_REQ-1:0]   req_reg,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [7:0]             rd_data,
  output logic [8:0]             dev_address_s,
  output logic [7:0]             reg_address_s,
  output logic [7:0]             data_s,
  input  logic                   eng_busy,
  input  logic                   eng_done,
  input  logic                   ack_failed,
  input  logic [7:0]             eng_rx
);

  localparam int LW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("i2c_bus_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  arb_state_e          state;
  logic [LW-1:0]       last_winner;
  logic [LW-1:0]       win_idx;
  logic [LW-1:0]       sel_idx;
  logic [NUM_REQ-1:0]  sel_oh;
  logic                sel_any;
  logic                nack;
  logic                timeout;

  rr_select #(.NUM_REQ(NUM_REQ), .LW(LW)) u_rr (
    .req         (req),
    .last_winner (last_winner),
    .winner      (sel_oh),
    .any         (sel_any)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (sel_oh[i]) sel_idx = LW'(i);
  end

`ifdef I2C_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] to_cnt;

  // Held at zero while idle, so it is cleared on ISSUE entry.
  always_ff @(posedge clock) begin
    if (reset || state == IDLE || state == RESP) to_cnt <= '0;
    else                                         to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state == ISSUE || state == RUN) &&
                   (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      gnt           <= '0;
      done          <= '0;
      err           <= 1'b0;
      rd_data       <= '0;
      dev_address_s <= '0;
      reg_address_s <= '0;
      data_s        <= '0;
      nack          <= 1'b0;
      win_idx       <= '0;
      last_winner   <= LW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: if (sel_any) begin
          win_idx       <= sel_idx;
          gnt           <= sel_oh;
          dev_address_s <= {1'b1, req_dev[int'(sel_idx)*7 +: 7], req_rw[sel_idx]};
          reg_address_s <= req_reg[int'(sel_idx)*8 +: 8];
          data_s        <= req_data[int'(sel_idx)*8 +: 8];
          state         <= ISSUE;
        end
        ISSUE: begin
          if (timeout) begin
            dev_address_s[START_BIT] <= 1'b0;
            done[win_idx]            <= 1'b1;
            err                      <= 1'b1;
            state                    <= RESP;
          end else if (eng_busy) begin
            dev_address_s[START_BIT] <= 1'b0;
            state                    <= RUN;
          end
        end
        RUN: begin
          if (timeout) begin
            done[win_idx] <= 1'b1;
            err           <= 1'b1;
            state         <= RESP;
          end else begin
            if (ack_failed) nack <= 1'b1;
            if (eng_done) begin
              if (dev_address_s[RW_BIT]) rd_data <= eng_rx;
              done[win_idx] <= 1'b1;
              // a NACK landing on the same edge as eng_done still counts
              err           <= nack | ack_failed;
              state         <= RESP;
            end
          end
        end
        RESP: begin
          done        <= '0;
          err         <= 1'b0;
          gnt         <= '0;
          nack        <= 1'b0;
          last_winner <= win_idx;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized transactions against a round-robin reference model.
module tb_i2c_bus_arbiter;
  localparam int N = 3;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0, req_rw = '0;
  logic [7*N-1:0] req_dev = '0;
  logic [8*N-1:0] req_reg = '0, req_data = '0;
  logic [N-1:0]   gnt, done;
  logic           err;
  logic [7:0]     rd_data, reg_address_s, data_s;
  logic [8:0]     dev_address_s;
  logic           eng_busy = 1'b0, eng_done = 1'b0, ack_failed = 1'b0;
  logic [7:0]     eng_rx = '0;

  int passed = 0, total = 0;

  i2c_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(50)) dut (
    .clock(clock), .reset(reset), .req(req), .req_rw(req_rw), .req_dev(req_dev),
    .req_reg(req_reg), .req_data(req_data), .gnt(gnt), .done(done), .err(err),
    .rd_data(rd_data), .dev_address_s(dev_address_s), .reg_address_s(reg_address_s),
    .data_s(data_s), .eng_busy(eng_busy), .eng_done(eng_done),
    .ack_failed(ack_failed), .eng_rx(eng_rx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // gnt and done must never be two-hot
  always @(negedge clock) if (!reset) begin
    chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    chk("done_onehot", 32'($countones(done) <= 1), 32'd1);
  end

  task automatic chk_idle(input string nm);
    chk({nm, ":gnt"}, 32'(gnt), 0);
    chk({nm, ":done"}, 32'(done), 0);
    chk({nm, ":err"}, 32'(err), 0);
    chk({nm, ":rd"}, 32'(rd_data), 0);
    chk({nm, ":dev"}, 32'(dev_address_s), 0);
    chk({nm, ":reg"}, 32'(reg_address_s), 0);
    chk({nm, ":data"}, 32'(data_s), 0);
  endtask

  // drop: 0 keep req, 1 drop at done, 2 drop right after grant.
  // side: requesters raised at grant and dropped again before done.
  task automatic do_txn(input string nm, input int idx, input logic [8:0] word,
                        input logic [7:0] rg, input logic [7:0] dat, input int nack_cyc,
                        input int run_len, input logic [7:0] rx, input logic exp_err,
                        input logic [7:0] exp_rd, input int drop, input logic [N-1:0] side);
    int n = 0;
    while (gnt == '0 && n < 20) begin tick(); n++; end
    chk({nm, ":gnt"}, 32'(gnt), 32'(1) << idx);
    if (drop == 2) req[idx] = 1'b0;
    req = req | side;
    chk({nm, ":dev_start"}, 32'(dev_address_s), 32'(word));
    chk({nm, ":reg"}, 32'(reg_address_s), 32'(rg));
    chk({nm, ":data"}, 32'(data_s), 32'(dat));
    tick();
    chk({nm, ":start_held"}, 32'(dev_address_s), 32'(word));
    eng_busy = 1'b1;
    tick();
    chk({nm, ":dev_run"}, 32'(dev_address_s), 32'({1'b0, word[7:0]}));
    for (int c = 0; c < run_len; c++) begin
      ack_failed = (c == nack_cyc);
      tick();
    end
    req = req & ~side;
    ack_failed = (nack_cyc == run_len);
    eng_done = 1'b1; eng_rx = rx;
    tick();
    eng_done = 1'b0; eng_busy = 1'b0; ack_failed = 1'b0; eng_rx = '0;
    chk({nm, ":done"}, 32'(done), 32'(1) << idx);
    chk({nm, ":err"}, 32'(err), 32'(exp_err));
    chk({nm, ":rd"}, 32'(rd_data), 32'(exp_rd));
    chk({nm, ":dev_stable"}, 32'(dev_address_s), 32'({1'b0, word[7:0]}));
    if (drop == 1) req[idx] = 1'b0;
    tick();
    chk({nm, ":done_clr"}, 32'(done), 0);
    chk({nm, ":idle_gap"}, 32'(gnt), 0);
  endtask

  typedef struct {
    logic [N-1:0] req, rw;
    int           idx;
    logic [6:0]   dev;
    logic [7:0]   rg, dat, rx;
    int           nack_cyc, run_len;
    logic         exp_err;
    logic [7:0]   exp_rd;
    int           drop;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int            last_m, w, n;
    logic [7:0]    rd_m;
    int            order[6];
    logic [N-1:0]  mask;
    logic          found;
    vecs[0] = '{req:3'b001, rw:3'b000, idx:0, dev:7'h1A, rg:8'h34, dat:8'h56, rx:8'h00, nack_cyc:-1, run_len:4,  exp_err:0, exp_rd:8'h00, drop:1};
    vecs[1] = '{req:3'b011, rw:3'b000, idx:1, dev:7'h22, rg:8'h01, dat:8'h02, rx:8'h11, nack_cyc:-1, run_len:2,  exp_err:0, exp_rd:8'h00, drop:1};
    vecs[2] = '{req:3'b011, rw:3'b000, idx:0, dev:7'h33, rg:8'h03, dat:8'h04, rx:8'h22, nack_cyc:-1, run_len:3,  exp_err:0, exp_rd:8'h00, drop:1};
    vecs[3] = '{req:3'b011, rw:3'b000, idx:1, dev:7'h44, rg:8'h05, dat:8'h06, rx:8'h33, nack_cyc:-1, run_len:1,  exp_err:0, exp_rd:8'h00, drop:1};
    vecs[4] = '{req:3'b010, rw:3'b010, idx:1, dev:7'h50, rg:8'h10, dat:8'h00, rx:8'hA5, nack_cyc:-1, run_len:5,  exp_err:0, exp_rd:8'hA5, drop:1};
    vecs[5] = '{req:3'b100, rw:3'b000, idx:2, dev:7'h3C, rg:8'h20, dat:8'h99, rx:8'h77, nack_cyc:0,  run_len:10, exp_err:1, exp_rd:8'hA5, drop:1};
    vecs[6] = '{req:3'b001, rw:3'b001, idx:0, dev:7'h0F, rg:8'h30, dat:8'h00, rx:8'h3C, nack_cyc:-1, run_len:3,  exp_err:0, exp_rd:8'h3C, drop:1};
    vecs[7] = '{req:3'b010, rw:3'b000, idx:1, dev:7'h7F, rg:8'hFF, dat:8'hEE, rx:8'h55, nack_cyc:3,  run_len:3,  exp_err:1, exp_rd:8'h3C, drop:1};
    vecs[8] = '{req:3'b100, rw:3'b000, idx:2, dev:7'h01, rg:8'h40, dat:8'h41, rx:8'h66, nack_cyc:-1, run_len:2,  exp_err:0, exp_rd:8'h3C, drop:2};
    vecs[9] = '{req:3'b101, rw:3'b101, idx:0, dev:7'h2B, rg:8'h50, dat:8'h51, rx:8'hFF, nack_cyc:-1, run_len:2,  exp_err:0, exp_rd:8'hFF, drop:1};

    tick(); tick();
    chk_idle("reset");
    reset = 1'b0;

    // vector table; first entry also checks the minimum start latency
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < N; i++) begin
        req_dev[i*7 +: 7]  = (i == vecs[v].idx) ? vecs[v].dev : ~vecs[v].dev;
        req_reg[i*8 +: 8]  = (i == vecs[v].idx) ? vecs[v].rg  : ~vecs[v].rg;
        req_data[i*8 +: 8] = (i == vecs[v].idx) ? vecs[v].dat : ~vecs[v].dat;
      end
      req_rw = vecs[v].rw;
      req = vecs[v].req;
      if (v == 0) begin
        tick();
        chk("latency_gnt", 32'(gnt), 32'h1);
        chk("latency_word", 32'(dev_address_s), 32'h134);
      end
      do_txn($sformatf("vec%0d", v), vecs[v].idx,
             {1'b1, vecs[v].dev, vecs[v].rw[vecs[v].idx]}, vecs[v].rg, vecs[v].dat,
             vecs[v].nack_cyc, vecs[v].run_len, vecs[v].rx, vecs[v].exp_err,
             vecs[v].exp_rd, vecs[v].drop, '0);
    end

    // requester 1 raises and drops while 0 is served: it must be skipped
    req_rw = '0;
    req_dev[6:0] = 7'h12; req_reg[7:0] = 8'h21; req_data[7:0] = 8'h43;
    req = 3'b001;
    do_txn("skip", 0, {1'b1, 7'h12, 1'b0}, 8'h21, 8'h43, -1, 3, 8'h00, 1'b0, 8'hFF, 1, 3'b010);
    repeat (3) tick();
    chk("skip_no_gnt", 32'(gnt), 0);

    // all requesters held: grants rotate
    order = '{1, 2, 0, 1, 2, 0};
    for (int i = 0; i < N; i++) begin
      req_dev[i*7 +: 7] = 7'(8'h60 + i); req_reg[i*8 +: 8] = 8'(8'h70 + i); req_data[i*8 +: 8] = 8'(8'h80 + i);
    end
    req = 3'b111;
    for (int t = 0; t < 6; t++)
      do_txn($sformatf("fair%0d", t), order[t], {1'b1, 7'(8'h60 + order[t]), 1'b0},
             8'(8'h70 + order[t]), 8'(8'h80 + order[t]), -1, 2, 8'h00, 1'b0, 8'hFF, 0, '0);
    req = '0;
    tick(); tick();

    // reset in the middle of RUN: no done, everything cleared, requester 0 next
    req = 3'b001;
    tick();
    eng_busy = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; eng_busy = 1'b0; req = '0;
    chk_idle("mid_reset");
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    chk("mid_reset_no_done", 32'(done), 0);
    tick();
    chk("mid_reset_no_done2", 32'(done), 0);
    req = 3'b011;
    tick();
    chk("post_reset_winner", 32'(gnt), 32'h1);
    req = '0;

`ifdef I2C_TIMEOUT_EN
    reset = 1'b1; tick(); reset = 1'b0;
    req = 3'b001;
    tick();
    n = 0;
    while (done == '0 && n < 200) begin tick(); n++; end
    chk("timeout_cycles", 32'(n), 32'd50);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_start", 32'(dev_address_s[8]), 0);
    chk("timeout_rd", 32'(rd_data), 0);
    req = '0;
    tick();
    chk("timeout_idle", 32'(gnt), 0);
`endif

    // randomized transactions against the round-robin reference model
    reset = 1'b1; tick(); reset = 1'b0;
    last_m = N - 1; rd_m = '0;
    for (int it = 0; it < 40; it++) begin
      int rl, nc;
      logic [7:0] rx;
      mask = N'($urandom_range(1, (1 << N) - 1));
      req_rw = N'($urandom);
      req_dev = 21'($urandom); req_reg = 24'($urandom); req_data = 24'($urandom);
      rl = $urandom_range(1, 6);
      nc = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rl) : -1;
      rx = 8'($urandom);
      found = 1'b0; w = 0;
      for (int k = 1; k <= N; k++)
        if (!found && mask[(last_m + k) % N]) begin w = (last_m + k) % N; found = 1'b1; end
      if (req_rw[w]) rd_m = rx;
      req = mask;
      do_txn($sformatf("rand%0d", it), w, {1'b1, req_dev[w*7 +: 7], req_rw[w]},
             req_reg[w*8 +: 8], req_data[w*8 +: 8], nc, rl, rx, nc >= 0, rd_m, 1, '0);
      last_m = w;
      req = '0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 200000: watchdog limit in clock cycles; used only when I2C_TIMEOUT_EN is defined.
REQ-003 clock  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  NUM_REQ  per-requester transaction request, level; held until that requester's done pulse.
REQ-006 req_rw  in  NUM_REQ  per-requester direction: 1 = read, 0 = write.
REQ-007 req_dev  in  7*NUM_REQ  per-requester 7-bit device address, requester i at bits [7i+6:7i].
REQ-008 req_reg  in  8*NUM_REQ  per-requester register address.
REQ-009 req_data  in  8*NUM_REQ  per-requester write data.
REQ-010 gnt  out  NUM_REQ  one-hot grant; indicates the engine currently serves that requester.
REQ-011 done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-012 err  out  1  qualifies done: 1 = NACK or timeout.
REQ-013 rd_data  out  8  read byte, valid in the done cycle of a read.
REQ-014 dev_address_s  out  9  engine address word: bit8 = start, [7:1] = device address, bit0 = rw.
REQ-015 reg_address_s  out  8  and data_s  out  8  engine register address and write byte.
REQ-016 eng_busy  in  1  engine is out of its idle state; eng_done  in  1  one-cycle pulse after stop; ack_failed  in  1  NACK seen; eng_rx  in  8  received byte.

Function
REQ-017 The FSM SHALL use the states IDLE, ISSUE, RUN, RESP.
REQ-018 IDLE: when any req bit is set, the block SHALL select the winner by round-robin starting at last_winner+1 (wrapping NUM_REQ-1 to 0), latch its rw, dev, reg and data, set gnt, and go to ISSUE on the next edge.
REQ-019 ISSUE: the block SHALL drive dev_address_s = {1, dev, rw} and hold bit8 high until eng_busy=1, then clear bit8 and go to RUN.
REQ-020 Outside ISSUE, dev_address_s[8] SHALL be 0, so the engine never restarts after its stop.
REQ-021 The rest of dev_address_s, reg_address_s and data_s SHALL stay stable from ISSUE until leaving RESP.
REQ-022 RUN: any ack_failed pulse SHALL set a sticky nack flag.
REQ-023 RUN: eng_done SHALL capture eng_rx into rd_data (reads only) and go to RESP.
REQ-024 RESP: for exactly one cycle, done[winner]=1 and err=nack.
REQ-025 On leaving RESP, the block SHALL update last_winner, clear gnt and nack, and return to IDLE.
REQ-026 A requester whose req drops before grant SHALL be skipped; once granted, a dropped req SHALL NOT abort the transaction.
REQ-027 Minimum latency SHALL be 3 cycles from req rising to eng start: 1 cycle to IDLE decision, ISSUE entry, and the first cycle of bit8 high.
REQ-028 Back-to-back transactions SHALL have at least one IDLE cycle between done and the next start.
REQ-029 If eng_done and ack_failed occur in the same cycle, err SHALL be 1.
REQ-030 The block SHALL be fair: with all req held, grants SHALL cycle 0,1,..,NUM_REQ-1,0.

Reset
REQ-031 Reset SHALL force IDLE, gnt=0, done=0, err=0, rd_data=0, dev_address_s=0, reg_address_s=0, data_s=0, nack=0 and last_winner=NUM_REQ-1, so requester 0 wins first.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction without a done pulse; the engine is reset from the same signal.

Configuration
REQ-033 With I2C_TIMEOUT_EN defined, a counter SHALL clear on ISSUE entry and count in ISSUE and RUN.
REQ-034 With I2C_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES-1 SHALL force RESP with err=1, rd_data unchanged, and drop bit8.
REQ-035 Without I2C_TIMEOUT_EN, no counter SHALL exist and ISSUE/RUN SHALL wait indefinitely.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding (IDLE=0, ISSUE=1, RUN=2, RESP=3) and the dev_address_s bit positions (START_BIT=8, RW_BIT=0).
REQ-037 The round-robin selector SHALL be one sub-module, rr_select: inputs req, last_winner; outputs a one-hot winner and an any flag; purely combinational.

Verification
REQ-038 Reset, then req=01, write dev=0x1A, reg=0x34, data=0x56 -> dev_address_s=0x134 until eng_busy, then 0x034; done[0] one cycle after eng_done; err=0.
REQ-039 req=11 held, both write -> grants in order 0,1,0,1; gnt never two-hot; one or more IDLE cycles between transactions.
REQ-040 Read on requester 1, eng_rx=0xA5 at eng_done -> rd_data=0xA5 with done[1]; err=0.
REQ-041 ack_failed pulse in RUN, eng_done 10 cycles later -> done and err=1 in the same cycle; nack cleared for the next transaction.
REQ-042 Reset asserted in RUN -> next cycle IDLE, all outputs 0, no done pulse.
REQ-043 I2C_TIMEOUT_EN with TIMEOUT_CYCLES=50, eng_busy never asserted -> done and err=1 exactly 50 cycles after ISSUE entry.
